test_sequencer_multi: RTL and testbench

// Parametrised multi-channel trigger sequencer, successor to the single-trigger test sequencer.

---
 rtl/test_sequencer_multi_if.sv | 28 ++
 rtl/test_sequencer_multi.sv | 113 +++++++++++
 tb/tb_test_sequencer_multi.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/test_sequencer_multi_if.sv
// Control, config and trigger bundle for the multi-channel trigger sequencer.
interface test_sequencer_multi_if #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned BURST_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   stagger;
  logic [BURST_W-1:0] burst_len;
  logic [NUM_CH-1:0]  ch_enable;
  logic [NUM_CH-1:0]  trigger;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] frame_count;

  modport master (
    output start, stop, mode, period, stagger, burst_len, ch_enable,
    input  trigger, busy, done, frame_count
  );

  modport slave (
    input  start, stop, mode, period, stagger, burst_len, ch_enable,
    output trigger, busy, done, frame_count
  );
endinterface

// File: rtl/test_sequencer_multi.sv
// Multi-channel frame trigger sequencer: one-cycle pulses per channel at a fixed
// stagger offset inside a programmable frame, continuous or counted burst.
module test_sequencer_multi #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned BURST_W = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  test_sequencer_multi_if.slave  bus
);
  localparam int unsigned OFF_W = CNT_W + $clog2(NUM_CH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_cnt;
  logic [BURST_W-1:0] r_burst_len;
  logic [BURST_W-1:0] r_frame_count;
  logic               r_mode;
  logic [NUM_CH-1:0]  r_en;
  logic [NUM_CH-1:0]  r_trigger;
  logic               r_busy;
  logic               r_done;
  logic [OFF_W-1:0]   r_off [NUM_CH];

  logic [CNT_W-1:0]   w_period_clamped;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_wrap;
  logic               w_last;
  logic [NUM_CH-1:0]  w_trig_start;
  logic [NUM_CH-1:0]  w_trig_run;

  assign w_period_clamped = (bus.period < CNT_W'(2)) ? CNT_W'(2) : bus.period;
  assign w_wrap           = (r_cnt == r_period - CNT_W'(1));
  assign w_cnt_next       = w_wrap ? '0 : r_cnt + CNT_W'(1);
  assign w_last           = r_mode && (r_frame_count == r_burst_len);

  // Phase 0 of the first frame is decided straight from the inputs being latched.
  always_comb begin
    w_trig_start = '0;
    w_trig_run   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_trig_start[k] = bus.ch_enable[k] && ((k == 0) || (bus.stagger == '0));
      w_trig_run[k]   = r_en[k] && (r_off[k] == OFF_W'(w_cnt_next));
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state       <= S_IDLE;
      r_period      <= '0;
      r_cnt         <= '0;
      r_burst_len   <= '0;
      r_frame_count <= '0;
      r_mode        <= 1'b0;
      r_en          <= '0;
      r_trigger     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) r_off[k] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_trigger <= '0;
          if (bus.start && !bus.stop) begin
            r_period    <= w_period_clamped;
            r_burst_len <= bus.burst_len;
            r_mode      <= bus.mode;
            r_en        <= bus.ch_enable;
            r_cnt       <= '0;
            for (int k = 0; k < NUM_CH; k++)
              r_off[k] <= OFF_W'(k) * OFF_W'(bus.stagger);
            if (bus.mode && (bus.burst_len == '0)) begin
              r_done        <= 1'b1;
              r_frame_count <= '0;
            end else begin
              r_state       <= S_RUN;
              r_busy        <= 1'b1;
              r_frame_count <= BURST_W'(1);
              r_trigger     <= w_trig_start;
            end
          end
        end
        S_RUN: begin
          // Stop outranks the natural end of a burst, so it never yields done.
          if (bus.stop) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_trigger <= '0;
          end else if (w_wrap && w_last) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_trigger <= '0;
          end else begin
            r_cnt     <= w_cnt_next;
            r_trigger <= w_trig_run;
            if (w_wrap) r_frame_count <= r_frame_count + BURST_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.trigger     = r_trigger;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.frame_count = r_frame_count;
endmodule

// File: tb/tb_test_sequencer_multi.sv
// Directed bench for test_sequencer_multi: default 4-channel build plus an
// 8-channel/12-bit build for offset suppression.
module tb_test_sequencer_multi;
  logic aclk;
  logic areset;
  int   checks;
  int   errors;

  test_sequencer_multi_if #(.NUM_CH(4), .CNT_W(16), .BURST_W(8)) bus4 ();
  test_sequencer_multi_if #(.NUM_CH(8), .CNT_W(12), .BURST_W(8)) bus8 ();

  test_sequencer_multi #(.NUM_CH(4), .CNT_W(16), .BURST_W(8)) u_dut4 (
    .aclk(aclk), .areset(areset), .bus(bus4)
  );
  test_sequencer_multi #(.NUM_CH(8), .CNT_W(12), .BURST_W(8)) u_dut8 (
    .aclk(aclk), .areset(areset), .bus(bus8)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Schedule from start in cycle 0: frame f begins at 1+f*P, channel k fires at phase k*stg.
  function automatic logic [15:0] exp_trig(input int nch, input int c, input int p,
                                           input int stg, input logic [15:0] en, input int burst);
    logic [15:0] e;
    int f, ph;
    e  = '0;
    f  = (c - 1) / p;
    ph = (c - 1) % p;
    if (burst < 0 || f < burst)
      for (int k = 0; k < nch; k++)
        if (en[k] && (k * stg == ph)) e[k] = 1'b1;
    return e;
  endfunction

  task automatic window(input string tag, input bit use8, input int cfrom, input int cto,
                        input int p, input int stg, input logic [15:0] en, input int burst,
                        input int nch);
    logic [15:0] o_trig;
    logic        o_busy, o_done, e_busy, e_done, running;
    logic [7:0]  o_fc, e_fc;
    for (int c = cfrom; c <= cto; c++) begin
      o_trig  = use8 ? 16'(bus8.trigger) : 16'(bus4.trigger);
      o_busy  = use8 ? bus8.busy : bus4.busy;
      o_done  = use8 ? bus8.done : bus4.done;
      o_fc    = use8 ? bus8.frame_count : bus4.frame_count;
      running = (burst < 0) || (((c - 1) / p) < burst);
      e_busy  = running;
      e_done  = (burst >= 0) && (c == 1 + burst * p);
      e_fc    = running ? 8'((c - 1) / p + 1) : 8'(burst);
      chk($sformatf("%s c%0d trigger", tag, c), 64'(o_trig),
          64'(exp_trig(nch, c, p, stg, en, burst)));
      chk($sformatf("%s c%0d busy", tag, c), 64'(o_busy), 64'(e_busy));
      chk($sformatf("%s c%0d done", tag, c), 64'(o_done), 64'(e_done));
      chk($sformatf("%s c%0d frame_count", tag, c), 64'(o_fc), 64'(e_fc));
      tick();
    end
  endtask

  task automatic go4(input logic mode, input int p, input int stg, input int burst,
                     input logic [3:0] en);
    bus4.mode      = mode;
    bus4.period    = 16'(p);
    bus4.stagger   = 16'(stg);
    bus4.burst_len = 8'(burst);
    bus4.ch_enable = en;
    bus4.start     = 1'b1;
    tick();
    bus4.start     = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    areset = 1'b1;
    bus4.start = 1'b0; bus4.stop = 1'b0; bus4.mode = 1'b0; bus4.period = '0;
    bus4.stagger = '0; bus4.burst_len = '0; bus4.ch_enable = '0;
    bus8.start = 1'b0; bus8.stop = 1'b0; bus8.mode = 1'b0; bus8.period = '0;
    bus8.stagger = '0; bus8.burst_len = '0; bus8.ch_enable = '0;
    tick();
    tick();
    chk("reset trigger", 64'(bus4.trigger), 64'h0);
    chk("reset busy", 64'(bus4.busy), 64'h0);
    chk("reset done", 64'(bus4.done), 64'h0);
    chk("reset frame_count", 64'(bus4.frame_count), 64'h0);
    areset = 1'b0;
    tick();

    // T1: burst of 3 frames, P=10, stagger 2
    go4(1'b1, 10, 2, 3, 4'hF);
    window("T1", 1'b0, 1, 6, 10, 2, 16'hF, 3, 4);
    chk("T1 c7 ch3 pulse", 64'(bus4.trigger), 64'h8);
    tick();
    window("T1", 1'b0, 8, 35, 10, 2, 16'hF, 3, 4);
    chk("T1 final frame_count", 64'(bus4.frame_count), 64'd3);

    // T2: offsets at or beyond the period are suppressed
    go4(1'b1, 4, 2, 2, 4'hF);
    window("T2", 1'b0, 1, 12, 4, 2, 16'hF, 2, 4);

    // T3: continuous at 48 kHz frame, stop after 5 frames
    go4(1'b0, 2083, 5, 0, 4'b0101);
    window("T3", 1'b0, 1, 5 * 2083 - 1, 2083, 5, 16'h5, -1, 4);
    bus4.stop = 1'b1;
    chk("T3 stop cycle busy", 64'(bus4.busy), 64'h1);
    chk("T3 stop cycle frame_count", 64'(bus4.frame_count), 64'd5);
    tick();
    bus4.stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("T3 after stop %0d busy", i), 64'(bus4.busy), 64'h0);
      chk($sformatf("T3 after stop %0d trigger", i), 64'(bus4.trigger), 64'h0);
      chk($sformatf("T3 after stop %0d done", i), 64'(bus4.done), 64'h0);
      chk($sformatf("T3 after stop %0d frame_count", i), 64'(bus4.frame_count), 64'd5);
      tick();
    end

    // T4: zero-length burst, period clamp, start+stop collision
    go4(1'b1, 10, 1, 0, 4'hF);
    window("T4 burst0", 1'b0, 1, 3, 10, 1, 16'hF, 0, 4);
    go4(1'b1, 1, 1, 2, 4'hF);
    window("T4 period1", 1'b0, 1, 6, 2, 1, 16'hF, 2, 4);
    go4(1'b1, 0, 1, 1, 4'hF);
    window("T4 period0", 1'b0, 1, 4, 2, 1, 16'hF, 1, 4);
    bus4.stop = 1'b1;
    go4(1'b1, 10, 0, 3, 4'hF);
    bus4.stop = 1'b0;
    chk("T4 start+stop busy", 64'(bus4.busy), 64'h0);
    chk("T4 start+stop trigger", 64'(bus4.trigger), 64'h0);
    chk("T4 start+stop frame_count", 64'(bus4.frame_count), 64'd1);
    tick();
    chk("T4 start+stop still idle", 64'(bus4.busy), 64'h0);

    // T5: second start mid-burst ignored, then reset mid-pulse
    go4(1'b1, 10, 3, 2, 4'b1011);
    window("T5", 1'b0, 1, 3, 10, 3, 16'hB, 2, 4);
    bus4.start = 1'b1; bus4.mode = 1'b0; bus4.period = 16'd5; bus4.ch_enable = 4'hF;
    bus4.stagger = 16'd1; bus4.burst_len = 8'd9;
    window("T5", 1'b0, 4, 4, 10, 3, 16'hB, 2, 4);
    bus4.start = 1'b0;
    window("T5", 1'b0, 5, 25, 10, 3, 16'hB, 2, 4);
    go4(1'b0, 10, 0, 0, 4'hF);
    chk("T5 pulse before reset", 64'(bus4.trigger), 64'hF);
    areset = 1'b1;
    #1;
    chk("T5 reset trigger", 64'(bus4.trigger), 64'h0);
    chk("T5 reset busy", 64'(bus4.busy), 64'h0);
    chk("T5 reset frame_count", 64'(bus4.frame_count), 64'h0);
    tick();
    areset = 1'b0;
    tick();

    // T6: 8-channel build, ch7 offset 4200 exceeds the 4095 frame
    bus8.mode = 1'b1; bus8.period = 12'd4095; bus8.stagger = 12'd600;
    bus8.burst_len = 8'd1; bus8.ch_enable = 8'hFF; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    window("T6", 1'b1, 1, 3600, 4095, 600, 16'hFF, 1, 8);
    chk("T6 c3601 ch6 pulse", 64'(bus8.trigger), 64'h40);
    tick();
    window("T6", 1'b1, 3602, 4097, 4095, 600, 16'hFF, 1, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
